ram_4x16_ctrl: RTL and testbench

//   Initiator-side controller for the 4x16 word RAM. Accepts single-word read/write requests
//   on a valid/ready handshake and drives the RAM's enable/write_enable/addr/data pins.

---
 rtl/ram_4x16_ctrl_if.sv | 28 ++
 rtl/ram_4x16_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_4x16_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_4x16_ctrl_if.sv
// Request/response bundle between a datapath initiator and the ram_4x16 controller.
// The controller takes the slave side; whoever issues reads/writes/clears takes the master side.
interface ram_4x16_ctrl_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_dados;
   logic              clear_req;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_dados;
   logic              busy;
   logic              clear_done;

   modport master (
      output req_valid, req_write, req_addr, req_dados, clear_req, resp_ready,
      input  req_ready, resp_valid, resp_dados, busy, clear_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_dados, clear_req, resp_ready,
      output req_ready, resp_valid, resp_dados, busy, clear_done
   );
endinterface

// File: rtl/ram_4x16_ctrl.sv
// Single-word read/write controller for the 4x16 RAM, plus an on-demand zeroing sweep.
// Every output is a register loaded from the next-state decode, so nothing glitches toward the RAM.
module ram_4x16_ctrl #(
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   ram_4x16_ctrl_if.slave    bus,
   output logic              mem_enable,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dados_out,
   input  logic [DATA_W-1:0] mem_dados_in
);
   localparam int              LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_CLEAR} state_t;

   state_t            r_state, w_state_next;
   logic              r_req_ready, w_req_ready_next;
   logic              r_resp_valid, w_resp_valid_next;
   logic              r_busy, w_busy_next;
   logic              r_clear_done, w_clear_done_next;
   logic              r_mem_en, w_mem_en_next;
   logic              r_mem_we, w_mem_we_next;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
   logic [DATA_W-1:0] r_resp_dados, w_resp_dados_next;
   logic [LAT_W-1:0]  r_lat, w_lat_next;

   // The address register doubles as the sweep counter during CLEAR.
   always_comb begin
      w_state_next      = r_state;
      w_mem_addr_next   = r_mem_addr;
      w_mem_wdata_next  = '0;
      w_resp_dados_next = r_resp_dados;
      w_lat_next        = r_lat;
      w_clear_done_next = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.clear_req) begin
               w_state_next    = S_CLEAR;
               w_mem_addr_next = '0;
            end else if (bus.req_valid && r_req_ready) begin
               w_mem_addr_next = bus.req_addr;
               if (bus.req_write) begin
                  w_state_next     = S_WRITE;
                  w_mem_wdata_next = bus.req_dados;
               end else begin
                  w_state_next = S_READ;
                  w_lat_next   = '0;
               end
            end
         end
         S_WRITE: w_state_next = S_IDLE;
         S_READ: begin
            if (r_lat == LAT_LAST) begin
               w_resp_dados_next = mem_dados_in;
               w_state_next      = S_RESP;
            end else begin
               w_lat_next = r_lat + 1'b1;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) w_state_next = S_IDLE;
         end
         S_CLEAR: begin
            if (r_mem_addr == '1) begin
               w_state_next      = S_IDLE;
               w_mem_addr_next   = '0;
               w_clear_done_next = 1'b1;
            end else begin
               w_mem_addr_next = r_mem_addr + 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      w_req_ready_next  = (w_state_next == S_IDLE);
      w_busy_next       = (w_state_next != S_IDLE);
      w_resp_valid_next = (w_state_next == S_RESP);
      w_mem_en_next     = (w_state_next == S_WRITE) || (w_state_next == S_READ) ||
                          (w_state_next == S_CLEAR);
      w_mem_we_next     = (w_state_next == S_WRITE) || (w_state_next == S_CLEAR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_clear_done <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_resp_dados <= '0;
         r_lat        <= '0;
      end else begin
         r_state      <= w_state_next;
         r_req_ready  <= w_req_ready_next;
         r_resp_valid <= w_resp_valid_next;
         r_busy       <= w_busy_next;
         r_clear_done <= w_clear_done_next;
         r_mem_en     <= w_mem_en_next;
         r_mem_we     <= w_mem_we_next;
         r_mem_addr   <= w_mem_addr_next;
         r_mem_wdata  <= w_mem_wdata_next;
         r_resp_dados <= w_resp_dados_next;
         r_lat        <= w_lat_next;
      end
   end

   assign bus.req_ready     = r_req_ready;
   assign bus.resp_valid    = r_resp_valid;
   assign bus.resp_dados    = r_resp_dados;
   assign bus.busy          = r_busy;
   assign bus.clear_done    = r_clear_done;
   assign mem_enable        = r_mem_en;
   assign mem_write_enable  = r_mem_we;
   assign mem_addr          = r_mem_addr;
   assign mem_dados_out     = r_mem_wdata;
endmodule

// File: tb/tb_ram_4x16_ctrl.sv
// Bench for ram_4x16_ctrl: a behavioural 4x16 RAM plus a transaction-level model
// (expected RAM writes, read addresses, read responses and clear pulses) checked every cycle.
module tb_ram_4x16_ctrl;
   localparam int AW = 2;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ram_4x16_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   logic          mem_enable, mem_write_enable;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dados_out, mem_dados_in;

   ram_4x16_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus.slave),
      .mem_enable       (mem_enable),
      .mem_write_enable (mem_write_enable),
      .mem_addr         (mem_addr),
      .mem_dados_out    (mem_dados_out),
      .mem_dados_in     (mem_dados_in)
   );

   // RAM stand-in: synchronous write, combinational read; junk on the bus when not reading.
   logic [DW-1:0] ram_mem [4];
   always @(posedge clk) if (mem_enable && mem_write_enable) ram_mem[mem_addr] <= mem_dados_out;
   assign mem_dados_in = (mem_enable && !mem_write_enable) ? ram_mem[mem_addr] : 16'hDEAD;

   // Transaction-level model
   logic [DW-1:0]    model_mem [4];
   logic [AW+DW-1:0] exp_wr[$];
   logic [AW-1:0]    exp_rd[$];
   logic [DW-1:0]    exp_resp[$];
   int done_exp = 0;
   int done_seen = 0;
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic model_accept(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (wr) begin
         model_mem[a] = d;
         exp_wr.push_back({a, d});
      end else begin
         exp_rd.push_back(a);
         exp_resp.push_back(model_mem[a]);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         exp_wr.push_back({AW'(i), {DW{1'b0}}});
         model_mem[i] = '0;
      end
      done_exp++;
   endtask

   // Per-cycle compare, sampled mid-cycle after the stimulus has settled.
   initial begin
      int edges;
      bit prev_hold;
      logic [DW-1:0] prev_data;
      logic [AW+DW-1:0] e;
      logic [AW-1:0] ea;
      edges = 0;
      prev_hold = 0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            edges = 0;
            prev_hold = 0;
         end else begin
            edges++;
            if (mem_enable && mem_write_enable) begin
               if (exp_wr.size() == 0) fail_now("unexpected_mem_write");
               else begin
                  e = exp_wr.pop_front();
                  check("mem_write", 32'({mem_addr, mem_dados_out}), 32'(e));
               end
            end
            if (mem_enable && !mem_write_enable) begin
               if (exp_rd.size() == 0) fail_now("unexpected_mem_read");
               else begin
                  ea = exp_rd.pop_front();
                  check("mem_read_addr", 32'(mem_addr), 32'(ea));
               end
            end
            if (!mem_write_enable) check("wdata_zero", 32'(mem_dados_out), 32'd0);
            if (edges >= 2) check("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
            if (prev_hold) begin
               check("resp_hold_valid", 32'(bus.resp_valid), 32'd1);
               check("resp_hold_data", 32'(bus.resp_dados), 32'(prev_data));
            end
            prev_hold = bus.resp_valid && !bus.resp_ready;
            prev_data = bus.resp_dados;
            if (bus.resp_valid && bus.resp_ready) begin
               if (exp_resp.size() == 0) fail_now("unexpected_resp");
               else check("resp_data", 32'(bus.resp_dados), 32'(exp_resp.pop_front()));
            end
            if (bus.clear_done) begin
               done_seen++;
               if (done_exp == 0) fail_now("unexpected_clear_done");
               else done_exp--;
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.req_ready) fail_now("wait_idle_timeout");
   endtask

   // Drive a request from a negedge; optionally raise clear_req in the same cycle.
   task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit with_clear, output int waits);
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_dados = d;
      bus.req_valid = 1'b1;
      waits = 0;
      if (with_clear) begin
         bus.clear_req = 1'b1;
         model_clear();
         @(negedge clk);
         bus.clear_req = 1'b0;
         waits = 1;
      end
      while (!bus.req_ready && waits < 50) begin @(negedge clk); waits++; end
      if (!bus.req_ready) fail_now("send_timeout");
      else model_accept(wr, a, d);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = AW'($urandom);
      bus.req_dados = DW'($urandom);
   endtask

   task automatic wait_resp(input int stall, output logic [DW-1:0] got);
      int n = 0;
      bus.resp_ready = 1'b0;
      got = '0;
      while (!bus.resp_valid && n < 50) begin @(negedge clk); n++; end
      if (!bus.resp_valid) begin
         fail_now("resp_timeout");
         return;
      end
      got = bus.resp_dados;
      for (int i = 0; i < stall; i++) begin
         check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   task automatic read_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
      int w;
      logic [DW-1:0] got;
      send(1'b0, a, '0, 1'b0, w);
      wait_resp(0, got);
      check(name, 32'(got), 32'(exp));
   endtask

   task automatic do_clear(output int lat);
      wait_idle();
      bus.clear_req = 1'b1;
      model_clear();
      @(negedge clk);
      bus.clear_req = 1'b0;
      lat = 1;
      while (!bus.clear_done && lat < 20) begin @(negedge clk); lat++; end
      if (!bus.clear_done) fail_now("clear_timeout");
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_clear_done"}, 32'(bus.clear_done), 32'd0);
      check({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_dout"}, 32'(mem_dados_out), 32'd0);
      check({tag, "_resp_dados"}, 32'(bus.resp_dados), 32'd0);
   endtask

   initial begin
      int w, lat, done_before, sel;
      logic [DW-1:0] got;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      logic [DW-1:0] vals [4];
      bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_dados = '0;
      bus.clear_req = 0; bus.resp_ready = 0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      #1 check("ready_before_edge", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(bus.req_ready), 32'd1);
      check("busy_after_edge", 32'(bus.busy), 32'd0);

      // 1: write then read @2, latency pinned
      send(1'b1, 2'd2, 16'hA5C3, 1'b0, w);
      wait_idle();
      send(1'b0, 2'd2, '0, 1'b0, w);
      check("t1_resp_not_yet", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      check("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("t1_resp_dados", 32'(bus.resp_dados), 32'hA5C3);
      wait_resp(0, got);

      // 2: back-to-back writes, reverse-order reads
      vals[0] = 16'h0001; vals[1] = 16'h0202; vals[2] = 16'h3030; vals[3] = 16'hFFFF;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         send(1'b1, AW'(i), vals[i], 1'b0, w);
         if (i > 0) check("t2_b2b_write_waits", 32'(w), 32'd1);
      end
      read_lit(2'd3, 16'hFFFF, "t2_rd3");
      read_lit(2'd2, 16'h3030, "t2_rd2");
      read_lit(2'd1, 16'h0202, "t2_rd1");
      read_lit(2'd0, 16'h0001, "t2_rd0");

      // 3: stalled response
      send(1'b0, 2'd1, '0, 1'b0, w);
      wait_resp(3, got);
      check("t3_rd1", 32'(got), 32'h0202);

      // 4: fill, clear sweep, all zero
      wait_idle();
      for (int i = 0; i < 4; i++) send(1'b1, AW'(i), 16'hBEEF, 1'b0, w);
      done_before = done_seen;
      do_clear(lat);
      check("t4_clear_done_latency", 32'(lat), 32'd5);
      check("t4_clear_done_pulses", 32'(done_seen - done_before), 32'd1);
      for (int i = 0; i < 4; i++) read_lit(AW'(i), 16'h0000, "t4_rd_zero");

      // 5: clear and write in the same cycle
      wait_idle();
      send(1'b1, 2'd0, 16'h1234, 1'b1, w);
      check("t5_write_after_clear_waits", 32'(w), 32'd5);
      read_lit(2'd0, 16'h1234, "t5_rd0");

      // 6: reset in the middle of a clear sweep
      wait_idle();
      for (int i = 0; i < 4; i++) send(1'b1, AW'(i), 16'hAAA0 | DW'(i), 1'b0, w);
      wait_idle();
      done_before = done_seen;
      bus.clear_req = 1'b1;
      exp_wr.push_back({2'd0, 16'h0000});
      exp_wr.push_back({2'd1, 16'h0000});
      @(negedge clk);
      bus.clear_req = 1'b0;
      w = 0;
      while (!(mem_enable && mem_addr == 2'd2) && w < 20) begin @(negedge clk); w++; end
      if (!(mem_enable && mem_addr == 2'd2)) fail_now("t6_sweep_timeout");
      #1 reset = 1'b1;
      #1 check_all_zero("t6_async");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_wr.delete();
      model_mem[0] = '0;
      model_mem[1] = '0;
      @(negedge clk);
      check("t6_no_clear_done", 32'(done_seen - done_before), 32'd0);
      read_lit(2'd0, 16'h0000, "t6_rd0");
      read_lit(2'd1, 16'h0000, "t6_rd1");
      read_lit(2'd2, 16'hAAA2, "t6_rd2");
      read_lit(2'd3, 16'hAAA3, "t6_rd3");

      // Randomized traffic against the model
      for (int n = 0; n < 120; n++) begin
         sel = int'($urandom_range(0, 11));
         a = AW'($urandom);
         d = DW'($urandom);
         wait_idle();
         if (sel == 0) begin
            do_clear(lat);
         end else if (sel == 1) begin
            send(1'b1, a, d, 1'b1, w);
         end else if (sel < 6) begin
            send(1'b1, a, d, 1'b0, w);
         end else begin
            send(1'b0, a, '0, 1'b0, w);
            wait_resp(int'($urandom_range(0, 3)), got);
         end
      end

      wait_idle();
      repeat (2) @(negedge clk);
      check("end_exp_wr_empty", 32'(exp_wr.size()), 32'd0);
      check("end_exp_resp_empty", 32'(exp_resp.size()), 32'd0);
      check("end_exp_rd_empty", 32'(exp_rd.size()), 32'd0);
      check("end_clear_done_owed", 32'(done_exp), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
